register_file: RTL and testbench
================================

Name: register_file

Overview:
Parametrised successor to the single-word register: a bank of 2**addr_width words with one synchronous write port and two independent combinational read ports. Each read port has its own output enable. Register 0 can optionally be hard-wired to zero. The block is the general-purpose register storage for the CPU datapath and feeds both ALU operand buses directly.

Parameters:
- word_width, default `WORD_WIDTH, data width of each register and each port.
- addr_width, default 3, address width; depth = 2**addr_width registers.
- zero_reg, default 0, when 1 register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- we  input  1  write enable.
- waddr  input  addr_width  write address.
- in  input  word_width  write data.
- oe_a  input  1  read port A output enable.
- raddr_a  input  addr_width  read port A address.
- out_a  output  word_width  read port A data.
- oe_b  input  1  read port B output enable.
- raddr_b  input  addr_width  read port B address.
- out_b  output  word_width  read port B data.

Behaviour:
- Reset:
  - One clock, synchronous, active-high; rst sampled at posedge clk.
  - rst=1 at an edge clears all registers to 0 in that single edge.
  - rst has priority over we in the same cycle; the write is dropped.
- Write:
  - On posedge clk with rst=0 and we=1, register[waddr] <= in.
  - All other registers hold.
  - Result is visible on the read ports after that edge (1-cycle write latency).
- Zero register: when zero_reg=1, a write to address 0 is discarded and register 0 reads 0 at all times.
- Read:
  - Purely combinational.
  - out_x = oe_x ? register[raddr_x] : 0, for x = A and B.
  - No read latency and no registered outputs.
- Ports A and B are fully independent:
  - Same address on both ports is legal; both return the same value.
  - Either port may alias waddr.
- Read/write collision (raddr_x == waddr, we=1, no optional feature): out_x shows the OLD contents until the clock edge.
- Outputs before the first reset are undefined (X permitted); the bench must reset first.
- oe_x=0 forces out_x to 0 regardless of address, reset state or bypass.
- Addresses span exactly 2**addr_width entries, so no out-of-range address exists.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - When we=1, rst=0, raddr_x == waddr, and not (zero_reg=1 and waddr=0), out_x = oe_x ? in : 0 combinationally in the same cycle.
  - The value seen therefore equals what the register will hold after the edge.
  - Bypass is suppressed while rst=1; the stored value is shown instead.
- Undefined: no bypass path; collision reads return the old contents as specified in Behaviour.
- The write timing and register contents are identical in both builds.

Test Plan (word_width=16, addr_width=3):
- Reset then read: rst=1 for 1 cycle, then oe_a=oe_b=1 sweeping raddr 0..7 -> out_a=out_b=0x0000 for every address.
- Write/readback: write 0x1111*i to register i for i=1..7, then read A=i, B=8-i -> out_a=0x1111*i and out_b=0x1111*(8-i), each visible from the cycle after its write.
- Output enable gating: register 3 holds 0x3333, oe_a=0, raddr_a=3 -> out_a=0x0000; oe_a=1 -> 0x3333 in the same cycle.
- Collision and reset priority:
  - we=1, waddr=5, in=0xBEEF, raddr_a=5, register 5 previously 0x5555 -> out_a=0x5555 before the edge (0xBEEF with REGFILE_BYPASS_EN), 0xBEEF after the edge.
  - Repeat with rst=1 -> register 5 = 0x0000 after the edge.
- Zero register: zero_reg=1, write 0xFFFF to address 0 -> out_a at raddr 0 stays 0x0000, including with REGFILE_BYPASS_EN defined.
- Reset mid-operation: fill all registers, assert rst for one cycle while we=1 to address 2 -> every register reads 0x0000 afterward, and address 2 does not hold the written data.

Source files
------------

// File: rtl/register_file.sv
// General-purpose register bank: one synchronous write port, two combinational read ports.
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module register_file #(
    parameter int unsigned word_width = `WORD_WIDTH,
    parameter int unsigned addr_width = 3,
    parameter int unsigned zero_reg   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [word_width-1:0] in,
    input  logic                  oe_a,
    input  logic [addr_width-1:0] raddr_a,
    output logic [word_width-1:0] out_a,
    input  logic                  oe_b,
    input  logic [addr_width-1:0] raddr_b,
    output logic [word_width-1:0] out_b
);

    localparam int unsigned DEPTH   = 2 ** addr_width;
    localparam bit          ZERO_EN = (zero_reg != 0);

    logic [word_width-1:0] r_regs [DEPTH];
    logic                  w_wr_ok;
    logic [word_width-1:0] w_rd_a;
    logic [word_width-1:0] w_rd_b;

    // Writes to the hard-wired zero register never land.
    assign w_wr_ok = we && !(ZERO_EN && (waddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs <= '{default: '0};
        end else if (w_wr_ok) begin
            r_regs[waddr] <= in;
        end
    end

    always_comb begin
        w_rd_a = r_regs[raddr_a];
        if (ZERO_EN && (raddr_a == '0)) begin
            w_rd_a = '0;
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the pending write; reset suppresses it so the stored value shows.
        if (!rst && w_wr_ok && (raddr_a == waddr)) begin
            w_rd_a = in;
        end
`endif
        out_a = oe_a ? w_rd_a : '0;
    end

    always_comb begin
        w_rd_b = r_regs[raddr_b];
        if (ZERO_EN && (raddr_b == '0)) begin
            w_rd_b = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (!rst && w_wr_ok && (raddr_b == waddr)) begin
            w_rd_b = in;
        end
`endif
        out_b = oe_b ? w_rd_b : '0;
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expectations, a monitor checks at negedge.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic        oe_a;
    logic [2:0]  raddr_a;
    logic        oe_b;
    logic [2:0]  raddr_b;
    logic [15:0] out_a;
    logic [15:0] out_b;
    logic [15:0] z_out_a;
    logic [15:0] z_out_b;

    register_file #(.word_width(16), .addr_width(3), .zero_reg(0)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .in(wdata),
        .oe_a(oe_a), .raddr_a(raddr_a), .out_a(out_a),
        .oe_b(oe_b), .raddr_b(raddr_b), .out_b(out_b)
    );

    register_file #(.word_width(16), .addr_width(3), .zero_reg(1)) dut_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .in(wdata),
        .oe_a(oe_a), .raddr_a(raddr_a), .out_a(z_out_a),
        .oe_b(oe_b), .raddr_b(raddr_b), .out_b(z_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          which;
        bit          ca;
        logic [15:0] ea;
        bit          cb;
        logic [15:0] eb;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   next_id = 0;
    bit   done    = 1'b0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic drive(input logic r, input logic w, input logic [2:0] wa, input logic [15:0] d,
                         input logic oa, input logic [2:0] ra, input logic ob, input logic [2:0] rb);
        rst = r; we = w; waddr = wa; wdata = d;
        oe_a = oa; raddr_a = ra; oe_b = ob; raddr_b = rb;
    endtask

    task automatic push(input int which, input bit ca, input logic [15:0] ea,
                        input bit cb, input logic [15:0] eb);
        exp_t e;
        e.id = next_id; e.which = which; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every negedge, drain and compare all pending expectations.
    initial begin
        exp_t        e;
        logic [15:0] ga;
        logic [15:0] gb;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e  = sb.pop_front();
                ga = (e.which == 0) ? out_a : z_out_a;
                gb = (e.which == 0) ? out_b : z_out_b;
                if (e.ca) begin
                    n_tests++;
                    if (ga !== e.ea) begin
                        n_fail++;
                        $display("FAIL chk%0d out_a dut%0d: got %h expected %h", e.id, e.which, ga, e.ea);
                    end
                end
                if (e.cb) begin
                    n_tests++;
                    if (gb !== e.eb) begin
                        n_fail++;
                        $display("FAIL chk%0d out_b dut%0d: got %h expected %h", e.id, e.which, gb, e.eb);
                    end
                end
            end
            if (done) break;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
        cycle();

        // Reset sweep: all zero on both ports.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(i));
            push(0, 1'b1, 16'h0000, 1'b1, 16'h0000);
            push(1, 1'b1, 16'h0000, 1'b1, 16'h0000);
            cycle();
        end

        // Writes 1..7; port A reads the previous write, visible one cycle later.
        for (int i = 1; i < 8; i++) begin
            v = 16'(16'h1111 * (i - 1));
            drive(1'b0, 1'b1, 3'(i), 16'(16'h1111 * i), 1'b1, 3'(i - 1), 1'b1, 3'd0);
            push(0, 1'b1, v, 1'b1, 16'h0000);
            cycle();
        end

        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(8 - i));
            push(0, 1'b1, 16'(16'h1111 * i), 1'b1, 16'(16'h1111 * (8 - i)));
            cycle();
        end

        // Output enable gating.
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 1'b1, 3'd3);
        push(0, 1'b1, 16'h0000, 1'b1, 16'h3333);
        cycle();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 3'd3);
        push(0, 1'b1, 16'h3333, 1'b1, 16'h0000);
        cycle();

        // Collision on register 5.
        drive(1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b1, 3'd5, 1'b0, 3'd5);
        push(0, 1'b1, BYP ? 16'hBEEF : 16'h5555, 1'b1, 16'h0000);
        cycle();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd5);
        push(0, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF);
        cycle();

        // Reset beats the write; no bypass while reset is high.
        drive(1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 1'b1, 3'd6);
        push(0, 1'b1, 16'hBEEF, 1'b1, 16'h6666);
        cycle();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 1'b1, 3'd6);
        push(0, 1'b1, 16'h0000, 1'b1, 16'h0000);
        cycle();

        // Refill, then reset mid-operation with a write to register 2.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 3'(i), 16'(16'hA000 + i), 1'b0, 3'd0, 1'b0, 3'd0);
            cycle();
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b1, 3'd7);
        push(0, 1'b1, 16'hA002, 1'b1, 16'hA007);
        push(1, 1'b1, 16'hA002, 1'b1, 16'hA007);
        cycle();
        drive(1'b1, 1'b1, 3'd2, 16'hDEAD, 1'b1, 3'd2, 1'b1, 3'd0);
        push(0, 1'b1, 16'hA002, 1'b1, 16'hA000);
        push(1, 1'b0, 16'h0000, 1'b1, 16'h0000);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(7 - i));
            push(0, 1'b1, 16'h0000, 1'b1, 16'h0000);
            cycle();
        end

        // Zero register: write 0xFFFF to address 0.
        drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 1'b1, 3'd0);
        push(1, 1'b1, 16'h0000, 1'b1, 16'h0000);
        push(0, 1'b1, BYP ? 16'hFFFF : 16'h0000, 1'b0, 16'h0000);
        cycle();
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 3'd0);
        push(1, 1'b1, 16'h0000, 1'b1, 16'h0000);
        push(0, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
        cycle();

        done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
